noc_writer: RTL



---
 rtl/noc_writer.sv | 109 ++++++++++
 1 files changed

// File: rtl/noc_writer.sv
// NoC injection port: pops pre-formatted flits from a show-ahead FIFO and drives the link,
// with per-VC credit flow control and head/body/tail framing checks.
module noc_writer #(
  parameter int WIDTH        = 8,
  parameter int NUM_VC       = 2,
  parameter int DEPTH_PER_VC = 8,
  parameter int N            = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  i_data_in,
  input  logic              i_empty,
  output logic              o_read_en,
  output logic [WIDTH-1:0]  o_flit_out,
  input  logic [NUM_VC-1:0] i_credits_in,
  output logic              o_proto_err
);

  localparam int VC_AW     = $clog2(NUM_VC);
  localparam int CW        = $clog2(DEPTH_PER_VC + 1);
  localparam int VALID_POS = WIDTH - 1;
  localparam int HEAD_POS  = WIDTH - 2;
  localparam int TAIL_POS  = WIDTH - 3;
  localparam int VC_POS    = WIDTH - 4;

  typedef enum logic {IDLE, PKT} state_t;

  state_t             state_q, state_d;
  logic [VC_AW-1:0]   lock_vc_q, lock_vc_d;
  logic [CW-1:0]      cred_q [NUM_VC];
  logic [CW-1:0]      cred_d [NUM_VC];
  logic [WIDTH-1:0]   flit_q, flit_d;
  logic               err_q, err_d;

  logic               vld, head, tail, cred_ok;
  logic [VC_AW-1:0]   vc;
  logic               send, drop, discard;

  // Excess credit returns are absorbed by clamping at the buffer depth.
  function automatic logic [CW-1:0] sat_cred(input logic [CW:0] x);
    if (x > (CW+1)'(DEPTH_PER_VC)) return CW'(DEPTH_PER_VC);
    else                           return x[CW-1:0];
  endfunction

  assign vld     = i_data_in[VALID_POS];
  assign head    = i_data_in[HEAD_POS];
  assign tail    = i_data_in[TAIL_POS];
  assign vc      = i_data_in[VC_POS -: VC_AW];
  assign cred_ok = (cred_q[vc] != '0);

  always_comb begin
    send      = 1'b0;
    drop      = 1'b0;
    discard   = 1'b0;
    state_d   = state_q;
    lock_vc_d = lock_vc_q;
    if (!i_empty && !rst) begin
      if (!vld) begin
        discard = 1'b1;
      end else if (state_q == IDLE) begin
        if (!head) begin
          drop = 1'b1;
        end else if (cred_ok) begin
          send = 1'b1;
          if (!tail) begin
            state_d   = PKT;
            lock_vc_d = vc;
          end
        end
      end else begin
        // Inside a packet only same-VC body/tail flits are legal.
        if (head || (vc != lock_vc_q)) begin
          drop = 1'b1;
        end else if (cred_ok) begin
          send = 1'b1;
          if (tail) state_d = IDLE;
        end
      end
    end
    flit_d = send ? i_data_in : '0;
    err_d  = drop;
    for (int v = 0; v < NUM_VC; v++) begin
      cred_d[v] = sat_cred({1'b0, cred_q[v]} + (CW+1)'(i_credits_in[v])
                           - (CW+1)'(send && (vc == VC_AW'(v))));
    end
  end

  assign o_read_en = send | drop | discard;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lock_vc_q <= '0;
      flit_q    <= '0;
      err_q     <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) cred_q[v] <= CW'(DEPTH_PER_VC);
    end else begin
      state_q   <= state_d;
      lock_vc_q <= lock_vc_d;
      flit_q    <= flit_d;
      err_q     <= err_d;
      for (int v = 0; v < NUM_VC; v++) cred_q[v] <= cred_d[v];
    end
  end

  assign o_flit_out  = flit_q;
  assign o_proto_err = err_q;

endmodule
